// File: rtl/analog_io_seq_ctrl.sv
// Analog pad mode controller: Wishbone-programmed, break-before-make sequencer
// that switches one pad at a time between analog and digital output. Optional LOCK register: ANALOG_IO_SEQ_CTRL_LOCK_EN.
module analog_io_seq_ctrl #(
  parameter int                  NUM_CH     = 6,
  parameter logic [31:0]         BASE_ADDR  = 32'h3000_0000,
  parameter int                  SETTLE_W   = 16,
  parameter logic [SETTLE_W-1:0] SETTLE_RST = 16'd100
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [NUM_CH-1:0] io_oeb,
  output logic [NUM_CH-1:0] io_out,
  output logic              irq
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RELEASE,
    ST_SETTLE
  } state_t;

  state_t              state, state_n;
  logic [CH_W-1:0]     ch, ch_n;
  logic [SETTLE_W-1:0] cnt, cnt_n;
  logic [NUM_CH-1:0]   applied, applied_n;
  logic [NUM_CH-1:0]   pending, force_n;
  logic                irq_n;

  logic [NUM_CH-1:0]   mode;
  logic [NUM_CH-1:0]   out_reg;
  logic [SETTLE_W-1:0] settle;

  logic                req, accept, wr_en;
  logic [5:0]          offset;
  logic [31:0]         byte_mask;
  logic [31:0]         rdata;

  assign req       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // The ack cycle blocks acceptance, so a held request is served every other cycle
  assign accept    = req & ~wbs_ack_o;
  assign wr_en     = accept & wbs_we_i;
  assign offset    = wbs_adr_i[7:2];
  assign byte_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  wire unused_bits = &{1'b0, wbs_adr_i[1:0], byte_mask[31:16], wbs_dat_i[31:16]};

`ifdef ANALOG_IO_SEQ_CTRL_LOCK_EN
  logic locked;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      locked <= 1'b0;
    end else if (wr_en && offset == 6'd4 && wbs_sel_i[0] && wbs_dat_i[0]) begin
      locked <= 1'b1;
    end
  end
`else
  localparam logic locked = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      mode    <= '0;
      out_reg <= '0;
      settle  <= SETTLE_RST;
    end else if (wr_en) begin
      case (offset)
        6'd0: if (!locked) mode <= (mode & ~byte_mask[NUM_CH-1:0]) |
                                   (wbs_dat_i[NUM_CH-1:0] & byte_mask[NUM_CH-1:0]);
        6'd1: out_reg <= (out_reg & ~byte_mask[NUM_CH-1:0]) |
                         (wbs_dat_i[NUM_CH-1:0] & byte_mask[NUM_CH-1:0]);
        6'd2: if (!locked) settle <= (settle & ~byte_mask[SETTLE_W-1:0]) |
                                     (wbs_dat_i[SETTLE_W-1:0] & byte_mask[SETTLE_W-1:0]);
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      6'd0: rdata[NUM_CH-1:0]   = mode;
      6'd1: rdata[NUM_CH-1:0]   = out_reg;
      6'd2: rdata[SETTLE_W-1:0] = settle;
      6'd3: begin
        rdata[0]          = (state != ST_IDLE);
        rdata[8 +: NUM_CH] = applied;
      end
`ifdef ANALOG_IO_SEQ_CTRL_LOCK_EN
      6'd4: rdata[0] = locked;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= (accept && !wbs_we_i) ? rdata : '0;
    end
  end

  always_comb begin
    state_n   = state;
    ch_n      = ch;
    cnt_n     = cnt;
    applied_n = applied;
    irq_n     = 1'b0;
    force_n   = '0;
    pending   = mode ^ applied;
    case (state)
      ST_IDLE: begin
        if (pending != '0) begin
          for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) ch_n = CH_W'(i);
          end
          state_n = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        cnt_n   = settle;
        state_n = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Commit takes MODE as it stands now, so mid-sequence writes win
        if (cnt == '0) begin
          applied_n[ch] = mode[ch];
          state_n       = ST_IDLE;
          irq_n         = ((mode ^ applied_n) == '0);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (state_n != ST_IDLE) force_n[ch_n] = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state   <= ST_IDLE;
      ch      <= '0;
      cnt     <= '0;
      applied <= '0;
      io_oeb  <= '1;
      io_out  <= '0;
      irq     <= 1'b0;
    end else begin
      state   <= state_n;
      ch      <= ch_n;
      cnt     <= cnt_n;
      applied <= applied_n;
      io_oeb  <= ~applied_n | force_n;
      io_out  <= out_reg & applied_n;
      irq     <= irq_n;
    end
  end

endmodule

// File: tb/tb_analog_io_seq_ctrl.sv
// Self-checking bench for analog_io_seq_ctrl: a cycle-timed behavioural model
// compared every cycle, plus directed checks with hand-computed expectations.
module tb_analog_io_seq_ctrl;

  localparam int NCH = 6;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc_i, stb_i, we_i;
  logic [3:0]  sel_i;
  logic [31:0] adr_i, dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [NCH-1:0] io_oeb, io_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  analog_io_seq_ctrl dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wbs_cyc_i(cyc_i),
    .wbs_stb_i(stb_i),
    .wbs_we_i (we_i),
    .wbs_sel_i(sel_i),
    .wbs_adr_i(adr_i),
    .wbs_dat_i(dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .io_oeb   (io_oeb),
    .io_out   (io_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: registers plus a time-stamped view of the single active switch
  int          cyc = 0;
  logic [NCH-1:0] m_mode = '0, m_out = '0, m_applied = '0;
  logic [15:0] m_settle = 16'd100;
  bit          m_lock = 1'b0;
  int          m_ch = -1;
  int          m_rel = -1, m_commit = -1;
  bit          m_ack = 1'b0, m_irq = 1'b0;
  logic [31:0] m_dat = '0;
  logic [NCH-1:0] e_oeb = '1, e_out = '0;
  int          last_accept = 0;
  int          irq_cnt = 0;

  always @(posedge clk) begin
    logic [31:0] rd, tmp;
    logic [NCH-1:0] pre_mode, pre_out, diff;
    bit acc;
    cyc++;
    if (!rst_n) begin
      m_mode = '0; m_out = '0; m_applied = '0; m_settle = 16'd100; m_lock = 1'b0;
      m_ch = -1; m_rel = -1; m_commit = -1;
      m_ack = 1'b0; m_irq = 1'b0; m_dat = '0; e_oeb = '1; e_out = '0;
    end else begin
      pre_mode = m_mode;
      pre_out  = m_out;
      acc = cyc_i && stb_i && (adr_i[31:8] == BASE[31:8]) && !m_ack;
      rd = '0;
      case (adr_i[7:2])
        6'd0: rd = 32'(m_mode);
        6'd1: rd = 32'(m_out);
        6'd2: rd = 32'(m_settle);
        6'd3: rd = {18'd0, m_applied, 7'd0, (m_ch >= 0)};
`ifdef ANALOG_IO_SEQ_CTRL_LOCK_EN
        6'd4: rd = 32'(m_lock);
`endif
        default: rd = '0;
      endcase
      m_irq = 1'b0;
      if (m_ch < 0) begin
        diff = pre_mode ^ m_applied;
        if (diff != '0) begin
          for (int i = NCH - 1; i >= 0; i--) if (diff[i]) m_ch = i;
          m_rel = cyc + 1;
          m_commit = -1;
        end
      end else if (cyc == m_rel) begin
        m_commit = cyc + int'(m_settle) + 1;
      end else if (cyc == m_commit) begin
        m_applied[m_ch] = pre_mode[m_ch];
        m_ch = -1;
        if (pre_mode == m_applied) m_irq = 1'b1;
      end
      e_oeb = ~m_applied;
      if (m_ch >= 0) e_oeb[m_ch] = 1'b1;
      e_out = pre_out & m_applied;
      m_ack = acc;
      m_dat = (acc && !we_i) ? rd : '0;
      if (acc) last_accept = cyc;
      if (acc && we_i) begin
        for (int b = 0; b < 4; b++) begin
          tmp = '0;
          case (adr_i[7:2])
            6'd0: if (!m_lock) begin tmp = 32'(m_mode);   if (sel_i[b]) tmp[8*b +: 8] = dat_i[8*b +: 8]; m_mode   = tmp[NCH-1:0]; end
            6'd1: begin             tmp = 32'(m_out);    if (sel_i[b]) tmp[8*b +: 8] = dat_i[8*b +: 8]; m_out    = tmp[NCH-1:0]; end
            6'd2: if (!m_lock) begin tmp = 32'(m_settle); if (sel_i[b]) tmp[8*b +: 8] = dat_i[8*b +: 8]; m_settle = tmp[15:0];   end
            default: ;
          endcase
        end
`ifdef ANALOG_IO_SEQ_CTRL_LOCK_EN
        if (adr_i[7:2] == 6'd4 && sel_i[0] && dat_i[0]) m_lock = 1'b1;
`endif
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      checkOutput("io_oeb", 32'(io_oeb), 32'(e_oeb));
      checkOutput("io_out", 32'(io_out), 32'(e_out));
      checkOutput("irq", 32'(irq), 32'(m_irq));
      checkOutput("ack", 32'(wbs_ack_o), 32'(m_ack));
      checkOutput("dat_o", wbs_dat_o, m_dat);
      if (irq === 1'b1) irq_cnt++;
    end
  end

  task automatic applyStimulus(input logic c, input logic s, input logic w,
                               input logic [3:0] sl, input logic [31:0] a, input logic [31:0] d);
    cyc_i = c; stb_i = s; we_i = w; sel_i = sl; adr_i = a; dat_i = d;
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] sl, output logic [31:0] rd);
    bit got = 0;
    rd = '0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, w, sl, a, d);
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (wbs_ack_o === 1'b1) begin
        got = 1;
        rd = wbs_dat_o;
      end
    end
    if (!got) checkOutput("ack_timeout", 32'(got), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] unused_rd;
    wb_xfer(1'b1, BASE | 32'(off), d, 4'hF, unused_rd);
  endtask

  task automatic wb_read(input logic [7:0] off, output logic [31:0] rd);
    wb_xfer(1'b0, BASE | 32'(off), 32'h0, 4'hF, rd);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_oeb(input int b, input logic v, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc && at < 0; i++) begin
      @(negedge clk);
      if (io_oeb[b] === v) at = cyc;
    end
    if (at < 0) checkOutput("oeb_wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int t, a0, a2, base_irq;
    bit seen, oeb0_low;
    logic [3:0] pat;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("reset_oeb", 32'(io_oeb), 32'h3F);
    checkOutput("reset_out", 32'(io_out), 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    wb_read(8'h0C, rd);
    checkOutput("reset_status", rd, 32'h0);
    wb_read(8'h08, rd);
    checkOutput("reset_settle", rd, 32'd100);

    // Single switch, SETTLE=5
    wb_write(8'h08, 32'd5);
    base_irq = irq_cnt;
    wb_write(8'h00, 32'h01);
    t = last_accept;
    wb_write(8'h04, 32'h01);
    wait_oeb(0, 1'b0, 40, a0);
    checkOutput("single_delay", 32'(a0 - t), 32'd8);
    checkOutput("single_out_same_cycle", 32'(io_out), 32'h01);
    checkOutput("single_irq_on_commit", 32'(irq), 32'h1);
    idle(4);
    checkOutput("single_irq_count", 32'(irq_cnt - base_irq), 32'd1);
    wb_read(8'h0C, rd);
    checkOutput("single_status", rd, 32'h100);

    // Multi-channel ordering, SETTLE=0
    wb_write(8'h08, 32'd0);
    wb_write(8'h00, 32'h00);
    idle(10);
    base_irq = irq_cnt;
    wb_write(8'h00, 32'h05);
    t = last_accept;
    wait_oeb(0, 1'b0, 20, a0);
    wait_oeb(2, 1'b0, 20, a2);
    checkOutput("multi_ch0_delay", 32'(a0 - t), 32'd3);
    checkOutput("multi_gap", 32'(a2 - a0), 32'd3);
    idle(4);
    checkOutput("multi_irq_count", 32'(irq_cnt - base_irq), 32'd1);

    // Mid-sequence MODE change, SETTLE=10
    wb_write(8'h00, 32'h00);
    idle(10);
    wb_write(8'h08, 32'd10);
    base_irq = irq_cnt;
    wb_write(8'h00, 32'h03);
    wb_write(8'h00, 32'h02);
    oeb0_low = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (io_oeb[0] === 1'b0) oeb0_low = 1;
    end
    checkOutput("mid_ch0_never_driven", 32'(oeb0_low), 32'd0);
    checkOutput("mid_oeb_final", 32'(io_oeb), 32'h3D);
    checkOutput("mid_irq_count", 32'(irq_cnt - base_irq), 32'd1);
    wb_read(8'h0C, rd);
    checkOutput("mid_status", rd, 32'h200);

    // Bus protocol
    idle(1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, BASE | 32'h0C, 32'h0);
    for (int i = 0; i < 4; i++) begin
      pat[i] = wbs_ack_o;
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("held_ack_pattern", 32'(pat), 32'b1010);
    idle(1);
    wb_read(8'h14, rd);
    checkOutput("unmapped_read", rd, 32'h0);
    seen = 0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0100, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wbs_ack_o === 1'b1) seen = 1;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("out_of_range_no_ack", 32'(seen), 32'd0);
    wb_xfer(1'b1, BASE, 32'h3F, 4'b0010, rd);
    wb_read(8'h00, rd);
    checkOutput("sel_masked_mode", rd, 32'h02);

    // Reset mid-sequence returns every pad to analog
    wb_write(8'h00, 32'h3F);
    idle(6);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midseq_reset_oeb", 32'(io_oeb), 32'h3F);
    checkOutput("midseq_reset_out", 32'(io_out), 32'h0);

`ifdef ANALOG_IO_SEQ_CTRL_LOCK_EN
    wb_write(8'h10, 32'h1);
    wb_write(8'h00, 32'h3F);
    wb_read(8'h00, rd);
    checkOutput("lock_mode_ignored", rd, 32'h0);
    idle(5);
    checkOutput("lock_no_sequence", 32'(io_oeb), 32'h3F);
    wb_write(8'h04, 32'h15);
    wb_read(8'h04, rd);
    checkOutput("lock_out_writable", rd, 32'h15);
    wb_read(8'h10, rd);
    checkOutput("lock_readback", rd, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(8'h10, rd);
    checkOutput("lock_cleared_by_reset", rd, 32'h0);
`else
    wb_write(8'h10, 32'h1);
    wb_read(8'h10, rd);
    checkOutput("lock_unmapped", rd, 32'h0);
`endif

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
